tile_scanner: RTL and testbench
===============================

Name: tile_scanner

Overview:
- Upstream feeder of the tile colour-lookup stage in the VGA board display.
- Generates 640x480@60 raster timing from the 50 MHz system clock with an internal divide-by-2 pixel enable.
- Maps each active pixel onto a 4x4 game board and emits that cell's 4-bit tile code, with aligned sync and blanking signals.
- Board contents are snapshotted once per frame, so a frame never tears.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- BOARD_X0, 120, left pixel column of the board
- BOARD_Y0, 40, top line of the board
- CELL_SIZE, 100, cell edge in pixels; board spans 4*CELL_SIZE each axis

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low
- board  in  64  cell (r,c) code at bits [4*(4r+c)+3 : 4*(4r+c)], r = row 0..3 top-down, c = column 0..3
- pix_ce  out  1  pixel enable, high every second clk
- value  out  4  tile code for the current pixel, to the colour stage
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_n  out  1  high during active video
- frame_start  out  1  one-clk pulse when the snapshot is taken

Behaviour:
- Reset: pix_ce=0, phase=0, h=0, v=0, value=4'd15, hsync=1, vsync=1, blank_n=0, frame_start=0, shadow board=0.
- Pixel enable:
  - A phase bit toggles every clk.
  - pix_ce is high when phase=1, so the first pix_ce is the 2nd clk after reset release.
- Counters:
  - h counts 0..799 and advances only on pix_ce.
  - At 799, h wraps to 0 and v increments.
  - v counts 0..524 and wraps to 0 after 524.
- Snapshot:
  - On the pix_ce where h=799 and v=524, board is copied into the shadow register.
  - frame_start pulses on that same clk.
  - Board changes at any other time have no effect until the next snapshot.
- Cell tracking (no dividers):
  - cx/cy (0..3) and sub-counters sx/sy (0..CELL_SIZE-1) are incremented alongside h/v.
  - sx resets when h=BOARD_X0 is entered; sy resets when v=BOARD_Y0 is entered.
  - When a sub-counter reaches CELL_SIZE-1, it wraps and the cell index increments.
  - Cell indices saturate at 3.
- Output timing:
  - All outputs are registered on pix_ce and describe the counter state before that edge: a one-pixel latency, identical for all outputs.
  - Outputs hold between pix_ce edges.
- hsync is low for h in [656,751]; vsync is low for v in [490,491].
- blank_n=1 iff h<640 and v<480.
- value:
  - Inside the board (BOARD_X0<=h<BOARD_X0+400 and BOARD_Y0<=v<BOARD_Y0+400): value = shadow cell (cy,cx).
  - Otherwise value=4'd15, including during blanking.
- Codes 12..15 pass through unmodified; the colour stage renders them as the default grey.
- Reset mid-frame: all state returns to reset values on the next clk edge, and the raster restarts at h=0, v=0.

Optional Feature:
- Macro: GRID_LINES_EN
- Defined:
  - Inside the board, pixels with sx<4 or sy<4 output value=4'd14, forming separator lines.
  - The last column (h=BOARD_X0+399) and last row (v=BOARD_Y0+399) also output 4'd14.
- Undefined: no separator lines; every board pixel carries its cell code. Timing is identical in both builds.

Test Plan:
- Reset held 3 clk, then released -> first hsync falling edge at 2*657 clk after release. The line period is 1600 clk and the frame period is 840000 clk. vsync is low for exactly 3200 clk per frame.
- board with cell i = i mod 12, after one snapshot -> with pixel (h,v) appearing one pixel later:
  - (120,40) gives 0
  - (219,40) gives 0
  - (220,40) gives 1
  - (519,439) gives 3 (cell 15)
  - (520,439) gives 15
  - (119,40) gives 15
- board changed from all 4'h5 to all 4'h7 at v=200 -> value stays 5 for the rest of the frame. It changes to 7 only after frame_start.
- blank_n check -> 0 for h>=640 or v>=480; value=15 whenever blank_n=0.
- rst_n pulsed low 1 clk at h=300, v=100 -> next clk shows reset values, and the counters restart from 0,0 with correct timing.
- GRID_LINES_EN defined, board all 4'h2 -> (120,40)=14, (124,44)=2, (220,100)=14, (519,300)=14.

Source files
------------

// File: rtl/tile_scanner.sv
// tile_scanner: 640x480@60 raster generator feeding the tile colour-lookup
// stage. Maps each active pixel onto a 4x4 board and emits that cell's
// 4-bit tile code alongside aligned sync/blank. The board is copied into a
// shadow register once per frame, so a frame never tears.
//
// Ports:
//   clk         in   50 MHz system clock
//   rst_n       in   synchronous active-low reset
//   board       in   64-bit board, cell (r,c) at [4*(4r+c) +: 4]
//   pix_ce      out  pixel enable, high every second clk
//   value       out  tile code for the current pixel (15 outside board)
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync
//   blank_n     out  high during active video
//   frame_start out  one-clk pulse when the board snapshot is taken
//
// Optional build macro GRID_LINES_EN: draws code-14 separator lines on the
// board (first 4 pixels of every cell row/column plus the last board
// column and row). Timing is identical either way.
module tile_scanner #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BOARD_X0  = 120,
  parameter int BOARD_Y0  = 40,
  parameter int CELL_SIZE = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] board,
  output logic        pix_ce,
  output logic [3:0]  value,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int CW      = $clog2(CELL_SIZE);
  localparam int BOARD_W = 4 * CELL_SIZE;

  logic          phase_q;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [63:0]   shadow_q;
  logic [3:0]    value_q, value_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d, fs_q;
  logic          h_end, v_end, in_x, in_y;
  logic [3:0]    cell_code;

  always_comb begin
    h_end = (int'(h_q) == H_TOTAL - 1);
    v_end = (int'(v_q) == V_TOTAL - 1);
    h_d   = h_end ? '0 : h_q + 1'b1;
    v_d   = v_q;
    if (h_end) v_d = v_end ? '0 : v_q + 1'b1;

    // Cell tracking by sub-counters instead of dividing h/v by CELL_SIZE.
    // Realigned on entry to the board edge; index saturates past the board.
    sx_d = sx_q;
    cx_d = cx_q;
    if (int'(h_d) == BOARD_X0) begin
      sx_d = '0;
      cx_d = '0;
    end else if (int'(sx_q) == CELL_SIZE - 1) begin
      sx_d = '0;
      cx_d = (cx_q == 2'd3) ? 2'd3 : cx_q + 2'd1;
    end else begin
      sx_d = sx_q + 1'b1;
    end

    sy_d = sy_q;
    cy_d = cy_q;
    if (h_end) begin
      if (int'(v_d) == BOARD_Y0) begin
        sy_d = '0;
        cy_d = '0;
      end else if (int'(sy_q) == CELL_SIZE - 1) begin
        sy_d = '0;
        cy_d = (cy_q == 2'd3) ? 2'd3 : cy_q + 2'd1;
      end else begin
        sy_d = sy_q + 1'b1;
      end
    end

    in_x      = (int'(h_q) >= BOARD_X0) && (int'(h_q) < BOARD_X0 + BOARD_W);
    in_y      = (int'(v_q) >= BOARD_Y0) && (int'(v_q) < BOARD_Y0 + BOARD_W);
    cell_code = shadow_q[{cy_q, cx_q, 2'b00} +: 4];

    value_d = (in_x && in_y) ? cell_code : 4'd15;
`ifdef GRID_LINES_EN
    if (in_x && in_y &&
        ((int'(sx_q) < 4) || (int'(sy_q) < 4) ||
         (int'(h_q) == BOARD_X0 + BOARD_W - 1) ||
         (int'(v_q) == BOARD_Y0 + BOARD_W - 1)))
      value_d = 4'd14;
`endif

    hsync_d = !((int'(h_q) >= H_ACTIVE + H_FP) &&
                (int'(h_q) <  H_ACTIVE + H_FP + H_SYNC));
    vsync_d = !((int'(v_q) >= V_ACTIVE + V_FP) &&
                (int'(v_q) <  V_ACTIVE + V_FP + V_SYNC));
    blank_d = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      shadow_q <= '0;
      value_q  <= 4'd15;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blank_q  <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      fs_q    <= 1'b0;
      if (phase_q) begin
        h_q     <= h_d;
        v_q     <= v_d;
        sx_q    <= sx_d;
        sy_q    <= sy_d;
        cx_q    <= cx_d;
        cy_q    <= cy_d;
        // Outputs describe the pre-edge counters: one pixel of latency.
        value_q <= value_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        blank_q <= blank_d;
        if (h_end && v_end) begin
          shadow_q <= board;
          fs_q     <= 1'b1;
        end
      end
    end
  end

  assign pix_ce      = phase_q;
  assign value       = value_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_tile_scanner.sv
// Directed bench for tile_scanner. The raster is shrunk through parameters
// (80x55 pixel frame, 10-pixel cells) so several frames fit in a short run;
// the expected values below are computed for that geometry.
// Pixel p of frame f (counted from reset release) appears on the outputs
// right after clk edge 2*(f*N + p + 1).
module tb_tile_scanner;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int X0 = 12, Y0 = 4, C = 10;
  localparam int HT = 80, VT = 55, N = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] board = '0;
  logic        pix_ce, hsync, vsync, blank_n, frame_start;
  logic [3:0]  value;

  int n_tests = 0, n_fail = 0, cyc = 0;

  tile_scanner #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BOARD_X0(X0), .BOARD_Y0(Y0), .CELL_SIZE(C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .board(board), .pix_ce(pix_ce),
    .value(value), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto_pix(input int f, input int h, input int v);
    int t;
    t = 2 * (f * N + v * HT + h + 1);
    while (cyc < t) tick();
  endtask

  task automatic fill(input logic [3:0] code);
    for (int i = 0; i < 16; i++) board[4*i +: 4] = code;
  endtask

  // Measure hsync falling edges from release; returns first edge and period.
  task automatic hs_measure(output int f1, output int f2);
    logic prev;
    prev = 1'b1; f1 = -1; f2 = -1;
    while (cyc < 400) begin
      tick();
      if (cyc == 1) chk("pix_ce_first", pix_ce, 1);
      if (cyc == 2) chk("pix_ce_second", pix_ce, 0);
      if (prev && !hsync) begin
        if (f1 < 0) f1 = cyc;
        else if (f2 < 0) f2 = cyc;
      end
      prev = hsync;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pix_ce"}, pix_ce, 0);
    chk({tag, "_value"}, value, 15);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_blank_n"}, blank_n, 0);
    chk({tag, "_frame_start"}, frame_start, 0);
  endtask

  initial begin
    int f1, f2, h, v, r, c, vlow;
    int e_val, e_hs, e_vs, e_bl, e_fs;
    logic [3:0] ev;
    logic inb;

    // cell i holds i mod 12
    for (int i = 0; i < 16; i++) board[4*i +: 4] = 4'(i % 12);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    cyc = 0;

    hs_measure(f1, f2);
    chk("hs_fall_first", f1, 2 * (HA + HF + 1));
    chk("hs_line_period", f2 - f1, 2 * HT);

    // frame 0: shadow still zero
    goto_pix(0, 11, 4);  chk("f0_left_of_board", value, 15);
    goto_pix(0, 17, 9);  chk("f0_shadow_zero", value, 0);
    goto_pix(0, 79, 54); chk("fs_pulse", frame_start, 1);
    tick();              chk("fs_one_clk", frame_start, 0);

    // frame 1: full sweep against a geometric model
    vlow = 0; e_val = 0; e_hs = 0; e_vs = 0; e_bl = 0; e_fs = 0;
    for (int p = 0; p < N; p++) begin
      h = p % HT; v = p / HT;
      if (p == 20 * HT) fill(4'h5);  // must not show until next frame
      goto_pix(1, h, v);
      inb = (h >= X0) && (h < X0 + 4*C) && (v >= Y0) && (v < Y0 + 4*C);
      ev = 4'd15;
      if (inb) begin
        r = (v - Y0) / C; c = (h - X0) / C;
        ev = 4'((4*r + c) % 12);
`ifdef GRID_LINES_EN
        if ((h - X0) % C < 4 || (v - Y0) % C < 4 || h == X0 + 4*C - 1 || v == Y0 + 4*C - 1)
          ev = 4'd14;
`endif
      end
      if (value !== ev) e_val++;
      if (hsync !== !(h >= HA + HF && h < HA + HF + HS)) e_hs++;
      if (vsync !== !(v >= VA + VF && v < VA + VF + VS)) e_vs++;
      if (blank_n !== (h < HA && v < VA)) e_bl++;
      if (frame_start !== (h == HT - 1 && v == VT - 1)) e_fs++;
      if (!vsync) vlow++;
`ifndef GRID_LINES_EN
      if (h == 12 && v == 4)  chk("pt_12_4",  value, 0);
      if (h == 21 && v == 4)  chk("pt_21_4",  value, 0);
      if (h == 22 && v == 4)  chk("pt_22_4",  value, 1);
      if (h == 51 && v == 43) chk("pt_51_43", value, 3);
      if (h == 52 && v == 43) chk("pt_52_43", value, 15);
      if (h == 11 && v == 4)  chk("pt_11_4",  value, 15);
`endif
    end
    chk("scan_value_errs", e_val, 0);
    chk("scan_hsync_errs", e_hs, 0);
    chk("scan_vsync_errs", e_vs, 0);
    chk("scan_blank_errs", e_bl, 0);
    chk("scan_fs_errs", e_fs, 0);
    chk("vsync_low_clks", vlow * 2, 2 * VS * HT);

    // frame 2: snapshot of all-5; change to all-7 mid-frame has no effect
    goto_pix(2, 17, 14); chk("f2_before_change", value, 5);
    goto_pix(2, 0, 20);  fill(4'h7);
    goto_pix(2, 17, 39); chk("f2_after_change", value, 5);
    goto_pix(2, 79, 54); chk("f2_fs", frame_start, 1);

    // frame 3: all-7 now visible
`ifdef GRID_LINES_EN
    goto_pix(3, 12, 4);  chk("grid_corner", value, 14);
    goto_pix(3, 16, 8);  chk("grid_inner", value, 7);
`endif
    goto_pix(3, 17, 9);  chk("f3_new_board", value, 7);
`ifdef GRID_LINES_EN
    goto_pix(3, 22, 10); chk("grid_cell_edge", value, 14);
    goto_pix(3, 51, 30); chk("grid_last_col", value, 14);
`endif

    // mid-frame reset pulse
    goto_pix(3, 30, 45);
    rst_n = 1'b0;
    tick();
    chk_reset("midrst");
    rst_n = 1'b1;
    cyc = 0;
    hs_measure(f1, f2);
    chk("midrst_hs_fall", f1, 2 * (HA + HF + 1));
    goto_pix(0, 17, 9);  chk("midrst_shadow_zero", value, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
